// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU control codes, exception causes,
// the EX/MEM trap state and the MEM-stage control bundle.
package mips_pkg;

  typedef enum logic [5:0] {
    ALU_AND   = 6'd0,
    ALU_OR    = 6'd1,
    ALU_XOR   = 6'd2,
    ALU_NOR   = 6'd3,
    ALU_ADD   = 6'd4,
    ALU_ADDU  = 6'd5,
    ALU_SUB   = 6'd6,
    ALU_SUBU  = 6'd7,
    ALU_SLT   = 6'd8,
    ALU_SLTU  = 6'd9,
    ALU_BEQ   = 6'd10,
    ALU_BNE   = 6'd11,
    ALU_BLT   = 6'd12,
    ALU_BGE   = 6'd13,
    ALU_BLTU  = 6'd14,
    ALU_BGEU  = 6'd15,
    ALU_LUI   = 6'd16,
    ALU_PASSB = 6'd17
  } alu_ctrl_e;

  localparam logic [4:0] EXC_CODE_NONE = 5'd0;
  localparam logic [4:0] EXC_CODE_OV   = 5'd12;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } stage_state_e;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  localparam mem_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/branch_target_adder.sv
// Branch redirect address: PC+4 plus the word-offset immediate scaled to bytes.
module branch_target_adder #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] pc_plus4_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] target_o
);

  logic [DATA_W-1:0] imm_bytes;

  assign imm_bytes = imm_i << 2;
  assign target_o  = pc_plus4_i + imm_bytes;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution and a precise
// overflow-trap state machine that bubbles the stage until ExcAck.
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ExValid,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic              Zero,
  input  logic              Overflow,
  input  logic [DATA_W-1:0] RtData,
  input  logic [DATA_W-1:0] PCPlus4,
  input  logic [DATA_W-1:0] BranchImm,
  input  logic [4:0]        WriteReg,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemToReg,
  input  logic              Branch,
  input  logic              OvfTrapEn,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              ExcAck,
  output logic              MValid,
  output logic              MRegWrite,
  output logic              MMemRead,
  output logic              MMemWrite,
  output logic              MMemToReg,
  output logic [DATA_W-1:0] MALUResult,
  output logic [DATA_W-1:0] MStoreData,
  output logic [4:0]        MWriteReg,
  output logic              BranchTaken,
  output logic [DATA_W-1:0] BranchTarget,
  output logic              ExcFlush,
  output logic              ExcPending,
  output logic [DATA_W-1:0] EPC,
  output logic [4:0]        ExcCause
);

  localparam logic [DATA_W-1:0] FOUR = DATA_W'(4);

  stage_state_e      state_q, state_d;
  mem_ctrl_t         ctrl_q, ctrl_d;
  logic [DATA_W-1:0] alu_q, alu_d, sdata_q, sdata_d;
  logic [DATA_W-1:0] tgt_q, tgt_d, epc_q, epc_d;
  logic [4:0]        wreg_q, wreg_d, cause_q, cause_d;
  logic              taken_q, taken_d, exc_flush_q, exc_flush_d;
  logic [DATA_W-1:0] target_sum;
  logic              ovf_trap;

  branch_target_adder #(.DATA_W(DATA_W)) u_branch_target_adder (
    .pc_plus4_i (PCPlus4),
    .imm_i      (BranchImm),
    .target_o   (target_sum)
  );

  assign ovf_trap = (state_q == RUN) & ExValid & ~Stall & ~Flush & Overflow & OvfTrapEn;

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    alu_d       = alu_q;
    sdata_d     = sdata_q;
    wreg_d      = wreg_q;
    tgt_d       = tgt_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    taken_d     = 1'b0;
    exc_flush_d = 1'b0;

    if (state_q == TRAP) begin
      // Everything arriving while trapped is a bubble, even on the ack cycle
      ctrl_d = CTRL_BUBBLE;
      if (ExcAck) state_d = RUN;
    end else if (ovf_trap) begin
      ctrl_d      = CTRL_BUBBLE;
      epc_d       = PCPlus4 - FOUR;
      cause_d     = EXC_CODE_OV;
      exc_flush_d = 1'b1;
      state_d     = TRAP;
    end else if (Flush) begin
      ctrl_d = CTRL_BUBBLE;
    end else if (Stall) begin
      ctrl_d = ctrl_q;
    end else if (ExValid) begin
      ctrl_d  = '{valid: 1'b1, reg_write: RegWrite, mem_read: MemRead,
                  mem_write: MemWrite, mem_to_reg: MemToReg};
      alu_d   = ALUResult;
      sdata_d = RtData;
      wreg_d  = WriteReg;
      if (Branch && !Zero) begin
        taken_d = 1'b1;
        tgt_d   = target_sum;
      end
    end else begin
      ctrl_d = CTRL_BUBBLE;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= RUN;
      ctrl_q      <= CTRL_BUBBLE;
      alu_q       <= '0;
      sdata_q     <= '0;
      wreg_q      <= '0;
      tgt_q       <= '0;
      epc_q       <= '0;
      cause_q     <= EXC_CODE_NONE;
      taken_q     <= 1'b0;
      exc_flush_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      alu_q       <= alu_d;
      sdata_q     <= sdata_d;
      wreg_q      <= wreg_d;
      tgt_q       <= tgt_d;
      epc_q       <= epc_d;
      cause_q     <= cause_d;
      taken_q     <= taken_d;
      exc_flush_q <= exc_flush_d;
    end
  end

  assign MValid       = ctrl_q.valid;
  assign MRegWrite    = ctrl_q.reg_write;
  assign MMemRead     = ctrl_q.mem_read;
  assign MMemWrite    = ctrl_q.mem_write;
  assign MMemToReg    = ctrl_q.mem_to_reg;
  assign MALUResult   = alu_q;
  assign MStoreData   = sdata_q;
  assign MWriteReg    = wreg_q;
  assign BranchTaken  = taken_q;
  assign BranchTarget = tgt_q;
  assign ExcFlush     = exc_flush_q;
  assign ExcPending   = (state_q == TRAP);
  assign EPC          = epc_q;
  assign ExcCause     = cause_q;

endmodule
